risc6_ifetch: RTL and testbench
===============================

# risc6_ifetch

Instruction supply and program-loader unit for `risc6_core`.
- Accepts a program as a byte stream over a valid/ready handshake and packs it big-endian into a 32-bit instruction memory.
- Holds the core in reset while loading, then releases it.
- Drives `instr` each cycle from the core's `pc`.
- Tracks run/halt state from the core's `halt`.

## Interface
- `AW`, 8: instruction memory address width; depth is 2^AW words.
- `HLT_WORD`, 32'hFC00_0000: word driven on `instr` whenever no valid program word exists. Opcode is 6'b111111.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_last`  in  1  marks the final byte of the program; qualified by `ld_valid`.
- `ld_ready`  out  1  loader byte accept.
- `start`  in  1  single-cycle run request.
- `pc`  in  32  program counter from the core.
- `halt`  in  1  halt flag from the core.
- `instr`  out  32  instruction to the core.
- `core_rst`  out  1  active-high reset to the core.
- `prog_len`  out  AW+1  number of words in the loaded program.
- `ld_err`  out  1  sticky overflow flag.
- `state`  out  2  current state: 00 IDLE, 01 LOAD, 10 RUN, 11 HALTED.

## Operation
- **Handshake**: a byte transfers on a posedge where `ld_valid && ld_ready`. `ld_ready` = 1 in IDLE, LOAD and HALTED; 0 in RUN.
- **IDLE**: `core_rst`=1, `instr`=HLT_WORD.
  - Accepted byte -> LOAD. That byte is the first byte of a new program.
  - `start` with `prog_len`≠0 -> RUN.
  - `start` with `prog_len`=0 is ignored.
- **Load start**: the first accepted byte of a load clears `wptr`, `byte_cnt`, `prog_len` and `ld_err`.
- **LOAD**: `core_rst`=1, `instr`=HLT_WORD.
  - Each byte shifts into `word` as `{word[23:0], ld_data}`, so the first byte is the MSB.
  - On the 4th byte (`byte_cnt`=3), write `mem[wptr]`, increment `wptr`, and set `byte_cnt` to 0.
- **Last byte** (`ld_last` on an accepted byte):
  - A partial word is left-justified, with unused low bytes written as zero, and is written to `mem[wptr]`.
  - `prog_len` = number of words written, including the partial word.
  - Next state is IDLE.
- **Overflow**: after 2^AW words have been written, further bytes are accepted and dropped, and `ld_err`=1.
  - `ld_last` still terminates the load, with `prog_len` = 2^AW.
- `start` in LOAD is ignored.
- **RUN**: `core_rst`=0.
  - `instr` = `mem[pc[AW-1:0]]` when the full 32-bit `pc` < `prog_len`, otherwise HLT_WORD. There is no aliasing of high `pc` bits.
  - `halt`=1 sampled -> HALTED.
  - `start` and `ld_valid` are ignored in RUN; no byte is consumed.
- **HALTED**: `core_rst`=0, so core registers stay observable. `instr`=HLT_WORD.
  - `start` -> IDLE; `core_rst` reasserts and clears the core's `pc` and `halt`.
  - Accepted byte -> LOAD.
  - If both occur in the same cycle, the byte wins.
- **Reset**: `state`=IDLE, `prog_len`=0, `ld_err`=0, `wptr`=0, `byte_cnt`=0.
  - Outputs during reset: `core_rst`=1, `ld_ready`=1, `instr`=HLT_WORD.
  - Memory contents are not reset.
  - Reset mid-load discards the partial program (`prog_len`=0).

## Timing
- `core_rst`, `ld_ready` and `state` decode from the state register only (Moore outputs, no combinational path from inputs).
- `instr` is a combinational function of `pc`, `prog_len`, `state` and memory, using an asynchronous-read array. Zero-cycle latency from `pc` to `instr`; the core samples it at its next posedge.
- Memory write occurs on the same posedge that accepts the 4th (or last) byte. The word is visible on `instr` from the following cycle.
- `start` sampled at edge N -> `state`=RUN and `core_rst`=0 after N. The core executes `mem[0]` at edge N+1.
- `halt` sampled at edge N -> HALTED after N. From then `instr`=HLT_WORD, so the core sees only HLT.
- `prog_len` updates on the edge accepting the last byte. A `start` at the next edge uses the new value.

## Test plan
- Load 00 00 00 05, FC 00 00 00 with `ld_last` on the 8th byte -> `prog_len`=2, IDLE. Then `start` -> RUN, `core_rst`=0, `instr`=0x00000005 at `pc`=0 and 0xFC000000 at `pc`=1. Core `halt` -> HALTED.
- Load 04 10 00 00, AB with `ld_last` on the 5th byte -> `prog_len`=2, `mem[1]`=0xAB000000. Drive `pc`=7 in RUN -> `instr`=0xFC000000.
- With AW=8, load 256 full words -> `prog_len`=256. Drive `pc`=0x100 -> `instr`=HLT_WORD, not `mem[0]`.
- With AW=2, send 17 bytes with the last flagged -> `prog_len`=4, `ld_err`=1, `mem[0..3]` hold the first 16 bytes. Starting a new load clears `ld_err`.
- Assert `rst_n`=0 after 3 bytes of a load -> IDLE, `prog_len`=0, `core_rst`=1. A following `start` is ignored and the state stays IDLE.
- Assert `ld_valid` during RUN -> `ld_ready`=0 and the byte is held until HALTED. In HALTED, the byte is accepted, the state goes to LOAD and `core_rst`=1. A `start` pulse in LOAD is ignored.

Source files
------------

// File: rtl/risc6_ifetch.sv
// Instruction supply and program loader for risc6_core: packs a byte stream
// big-endian into word memory, gates core reset and tracks run/halt state.
module risc6_ifetch #(
  parameter int unsigned AW       = 8,
  parameter logic [31:0] HLT_WORD = 32'hFC00_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          start,
  input  logic [31:0]   pc,
  input  logic          halt,
  output logic [31:0]   instr,
  output logic          core_rst,
  output logic [AW:0]   prog_len,
  output logic          ld_err,
  output logic [1:0]    state
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_RUN    = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_wcnt;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_word;
  logic [CW-1:0] r_prog_len;
  logic          r_ld_err;

  logic          w_acc;
  logic          w_first;
  logic [CW-1:0] w_wcnt;
  logic [1:0]    w_bcnt;
  logic [23:0]   w_word;
  logic          w_full;
  logic          w_wr;
  logic [31:0]   w_shift;
  logic [31:0]   w_wdata;
  logic [CW-1:0] w_len_nxt;

  // The first byte of any load sees cleared pointers, so a new program
  // always starts at word 0 regardless of what was there before.
  assign w_acc     = ld_valid && ld_ready;
  assign w_first   = w_acc && (r_state != S_LOAD);
  assign w_wcnt    = w_first ? '0 : r_wcnt;
  assign w_bcnt    = w_first ? 2'd0 : r_byte_cnt;
  assign w_word    = w_first ? 24'd0 : r_word;
  assign w_full    = w_wcnt[AW];
  assign w_shift   = {w_word, ld_data};
  assign w_wr      = w_acc && !w_full && ((w_bcnt == 2'd3) || ld_last);
  assign w_len_nxt = w_wr ? (w_wcnt + CW'(1)) : w_wcnt;

  // Left-justify a partial final word, zero-filling the unused low bytes.
  always_comb begin
    w_wdata = w_shift;
    case (w_bcnt)
      2'd0:    w_wdata = {w_shift[7:0], 24'd0};
      2'd1:    w_wdata = {w_shift[15:0], 16'd0};
      2'd2:    w_wdata = {w_shift[23:0], 8'd0};
      default: w_wdata = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b1;
    core_rst    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt = ld_last ? S_IDLE : S_LOAD;
        end else if (start && (r_prog_len != '0)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_LOAD: begin
        if (w_acc && ld_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        ld_ready = 1'b0;
        core_rst = 1'b0;
        if (halt) begin
          w_state_nxt = S_HALTED;
        end
      end
      default: begin
        core_rst = 1'b0;
        if (w_acc) begin
          w_state_nxt = ld_last ? S_IDLE : S_LOAD;
        end else if (start) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= '0;
      r_byte_cnt <= 2'd0;
      r_word     <= 24'd0;
      r_prog_len <= '0;
      r_ld_err   <= 1'b0;
    end else if (w_acc) begin
      r_wcnt     <= w_len_nxt;
      r_word     <= w_shift[23:0];
      r_ld_err   <= w_full | (r_ld_err & ~w_first);
      r_prog_len <= ld_last ? w_len_nxt : (w_first ? '0 : r_prog_len);
      if (w_full) begin
        r_byte_cnt <= w_bcnt;
      end else if ((w_bcnt == 2'd3) || ld_last) begin
        r_byte_cnt <= 2'd0;
      end else begin
        r_byte_cnt <= w_bcnt + 2'd1;
      end
    end
  end

  // Instruction memory is not reset; only prog_len gates what is visible.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wcnt[AW-1:0]] <= w_wdata;
    end
  end

  always_comb begin
    instr = HLT_WORD;
    if ((r_state == S_RUN) && (pc < 32'(r_prog_len))) begin
      instr = r_mem[pc[AW-1:0]];
    end
  end

  assign prog_len = r_prog_len;
  assign ld_err   = r_ld_err;
  assign state    = r_state;

endmodule

// File: tb/tb_risc6_ifetch.sv
// Directed self-checking bench for risc6_ifetch: an AW=8 instance for the main
// flows and an AW=2 instance for loader overflow.
module tb_risc6_ifetch;

  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic        clk;
  logic        rst_n;
  logic        ld_valid, ld_last, start, halt, ld_ready, core_rst, ld_err;
  logic [7:0]  ld_data;
  logic [31:0] pc, instr;
  logic [8:0]  prog_len;
  logic [1:0]  state;

  logic        b_ld_valid, b_ld_last, b_start, b_halt, b_ld_ready, b_core_rst, b_ld_err;
  logic [7:0]  b_ld_data;
  logic [31:0] b_pc, b_instr;
  logic [2:0]  b_prog_len;
  logic [1:0]  b_state;

  int errors = 0;
  int checks = 0;

  risc6_ifetch #(.AW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .start(start), .pc(pc),
    .halt(halt), .instr(instr), .core_rst(core_rst), .prog_len(prog_len),
    .ld_err(ld_err), .state(state)
  );

  risc6_ifetch #(.AW(2)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
    .ld_last(b_ld_last), .ld_ready(b_ld_ready), .start(b_start), .pc(b_pc),
    .halt(b_halt), .instr(b_instr), .core_rst(b_core_rst), .prog_len(b_prog_len),
    .ld_err(b_ld_err), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic send(input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d, input logic last);
    b_ld_valid = 1'b1; b_ld_data = d; b_ld_last = last;
    @(posedge clk); #1;
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1; @(posedge clk); #1; halt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%h exp=%h", state, 2'b00); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    checks++; if (instr !== HLT) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr, HLT); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL reset_ld_err got=%b exp=0", ld_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_run();
    logic [7:0] bytes [8] = '{8'h00, 8'h00, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
    pulse_start();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL empty_start_state got=%h exp=%h", state, 2'b00); end
    for (int i = 0; i < 8; i++) send(bytes[i], i == 7);
    checks++; if (prog_len !== 9'd2) begin errors++; $display("FAIL lr_prog_len got=%0d exp=2", prog_len); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL lr_state_idle got=%h exp=%h", state, 2'b00); end
    pc = 32'd0; #1;
    checks++; if (instr !== HLT) begin errors++; $display("FAIL lr_idle_instr got=%h exp=%h", instr, HLT); end
    pulse_start();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL lr_run_state got=%h exp=%h", state, 2'b10); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL lr_run_core_rst got=%b exp=0", core_rst); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL lr_run_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (instr !== 32'h0000_0005) begin errors++; $display("FAIL lr_instr_pc0 got=%h exp=%h", instr, 32'h5); end
    pc = 32'd1; #1;
    checks++; if (instr !== 32'hFC00_0000) begin errors++; $display("FAIL lr_instr_pc1 got=%h exp=%h", instr, 32'hFC000000); end
    pc = 32'd2; #1;
    checks++; if (instr !== HLT) begin errors++; $display("FAIL lr_instr_pc2 got=%h exp=%h", instr, HLT); end
    pc = 32'd0;
    pulse_halt();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL lr_halted_state got=%h exp=%h", state, 2'b11); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL lr_halted_core_rst got=%b exp=0", core_rst); end
    checks++; if (instr !== HLT) begin errors++; $display("FAIL lr_halted_instr got=%h exp=%h", instr, HLT); end
  endtask

  task automatic test_partial();
    send(8'h04, 1'b0);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL pw_load_state got=%h exp=%h", state, 2'b01); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL pw_load_core_rst got=%b exp=1", core_rst); end
    send(8'h10, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'hAB, 1'b1);
    checks++; if (prog_len !== 9'd2) begin errors++; $display("FAIL pw_prog_len got=%0d exp=2", prog_len); end
    pulse_start();
    pc = 32'd0; #1;
    checks++; if (instr !== 32'h0410_0000) begin errors++; $display("FAIL pw_instr_pc0 got=%h exp=%h", instr, 32'h04100000); end
    pc = 32'd1; #1;
    checks++; if (instr !== 32'hAB00_0000) begin errors++; $display("FAIL pw_instr_pc1 got=%h exp=%h", instr, 32'hAB000000); end
    pc = 32'd7; #1;
    checks++; if (instr !== HLT) begin errors++; $display("FAIL pw_instr_pc7 got=%h exp=%h", instr, HLT); end
    pulse_halt();
    pulse_start();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL pw_halt_start_state got=%h exp=%h", state, 2'b00); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL pw_halt_start_core_rst got=%b exp=1", core_rst); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = {8'hA5, 8'(i), ~8'(i), 8'(i + 1)};
      send(w[31:24], 1'b0); send(w[23:16], 1'b0); send(w[15:8], 1'b0);
      send(w[7:0], i == 255);
    end
    checks++; if (prog_len !== 9'h100) begin errors++; $display("FAIL full_prog_len got=%0d exp=256", prog_len); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL full_ld_err got=%b exp=0", ld_err); end
    pulse_start();
    pc = 32'd0; #1;
    checks++; if (instr !== 32'hA500_FF01) begin errors++; $display("FAIL full_instr_pc0 got=%h exp=%h", instr, 32'hA500FF01); end
    pc = 32'd255; #1;
    checks++; if (instr !== 32'hA5FF_0000) begin errors++; $display("FAIL full_instr_pc255 got=%h exp=%h", instr, 32'hA5FF0000); end
    pc = 32'h100; #1;
    checks++; if (instr !== HLT) begin errors++; $display("FAIL full_instr_pc256 got=%h exp=%h", instr, HLT); end
    pc = 32'h8000_0000; #1;
    checks++; if (instr !== HLT) begin errors++; $display("FAIL full_instr_pchigh got=%h exp=%h", instr, HLT); end
    pc = 32'd0;
    pulse_halt();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    for (int k = 0; k < 17; k++) b_send(8'(k + 1), k == 16);
    checks++; if (b_prog_len !== 3'd4) begin errors++; $display("FAIL ovf_prog_len got=%0d exp=4", b_prog_len); end
    checks++; if (b_ld_err !== 1'b1) begin errors++; $display("FAIL ovf_ld_err got=%b exp=1", b_ld_err); end
    checks++; if (b_state !== 2'b00) begin errors++; $display("FAIL ovf_state got=%h exp=%h", b_state, 2'b00); end
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_pc = 32'(i); #1;
      checks++; if (b_instr !== exp_w[i]) begin errors++; $display("FAIL ovf_mem%0d got=%h exp=%h", i, b_instr, exp_w[i]); end
    end
    b_pc = 32'd4; #1;
    checks++; if (b_instr !== HLT) begin errors++; $display("FAIL ovf_instr_pc4 got=%h exp=%h", b_instr, HLT); end
    b_halt = 1'b1; @(posedge clk); #1; b_halt = 1'b0;
    b_send(8'h55, 1'b0);
    checks++; if (b_ld_err !== 1'b0) begin errors++; $display("FAIL ovf_err_clear got=%b exp=0", b_ld_err); end
    checks++; if (b_prog_len !== 3'd0) begin errors++; $display("FAIL ovf_len_clear got=%0d exp=0", b_prog_len); end
  endtask

  task automatic test_reset_midload();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rml_load_state got=%h exp=%h", state, 2'b01); end
    rst_n = 1'b0; #2;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rml_state got=%h exp=%h", state, 2'b00); end
    checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL rml_prog_len got=%0d exp=0", prog_len); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rml_core_rst got=%b exp=1", core_rst); end
    @(posedge clk); #1; rst_n = 1'b1;
    pulse_start();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rml_start_ignored got=%h exp=%h", state, 2'b00); end
  endtask

  task automatic test_run_hold();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    pulse_start();
    pc = 32'd0;
    ld_valid = 1'b1; ld_data = 8'h77; ld_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL hold_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL hold_state_run got=%h exp=%h", state, 2'b10); end
    checks++; if (instr !== 32'h1122_3344) begin errors++; $display("FAIL hold_instr got=%h exp=%h", instr, 32'h11223344); end
    pulse_halt();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL hold_halted got=%h exp=%h", state, 2'b11); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL hold_halted_ready got=%b exp=1", ld_ready); end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL hold_load_state got=%h exp=%h", state, 2'b01); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL hold_load_core_rst got=%b exp=1", core_rst); end
    pulse_start();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL hold_load_start got=%h exp=%h", state, 2'b01); end
    send(8'h88, 1'b1);
    checks++; if (prog_len !== 9'd1) begin errors++; $display("FAIL hold_prog_len got=%0d exp=1", prog_len); end
    pulse_start();
    pc = 32'd0; #1;
    checks++; if (instr !== 32'h7788_0000) begin errors++; $display("FAIL hold_instr_new got=%h exp=%h", instr, 32'h77880000); end
  endtask

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    start = 1'b0; halt = 1'b0; pc = 32'd0;
    b_ld_valid = 1'b0; b_ld_data = 8'h00; b_ld_last = 1'b0;
    b_start = 1'b0; b_halt = 1'b0; b_pc = 32'd0;
    test_reset();
    test_load_run();
    test_partial();
    test_full();
    test_overflow();
    test_reset_midload();
    test_run_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
